// File: rtl/uc_asteroide.sv
// uc_asteroide: control unit for the asteroid table of the game. It sequences
// a slot counter over 16 asteroid slots to spawn, move, retire and destroy asteroids.
// Latency: registered Moore state; a spawn takes 2 cycles per visited slot + 2; a move scan takes 3/4/6 cycles per slot + 1.
// Backpressure: spawn/tick_move are sampled only in ESPERA (pronto=1); requests made while busy are dropped.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   iniciar                   start of session (accepted in IDLE only)
//   spawn, tick_move          operation requests (accepted in ESPERA only, spawn wins)
//   rco_contador_aste         slot counter is at the last slot
//   loaded_aste, destruido_aste, colisao_aste_com_nave, opcode_aste,
//   aste_coor_x, aste_coor_y  status of the slot addressed by the counter
//   conta/reset_contador_aste slot counter increment / clear
//   select_mux_pos_aste       write data: 00 sum->x, 01 sum->y, 10 random, 11 hold
//   select_mux_coor_aste      adder operand: 0 x, 1 y
//   select_soma_sub_aste      adder op: 0 add, 1 subtract
//   enable_mem_aste           position memory write
//   enable_load_aste          load/destroyed memory write with new_load_aste/new_destruido_aste
//   reset_memoria_load        clears every load/destroyed flag
//   reset_gerador_random, reset_reg_nave, enable_reg_nave   auxiliary datapath controls
//   pronto, fim_varredura, sem_espaco, colisao, db_estado   status and debug

module uc_asteroide (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       spawn,
  input  logic       tick_move,
  input  logic       rco_contador_aste,
  input  logic       loaded_aste,
  input  logic       destruido_aste,
  input  logic       colisao_aste_com_nave,
  input  logic [1:0] opcode_aste,
  input  logic [3:0] aste_coor_x,
  input  logic [3:0] aste_coor_y,
  output logic       conta_contador_aste,
  output logic       reset_contador_aste,
  output logic [1:0] select_mux_pos_aste,
  output logic       select_mux_coor_aste,
  output logic       select_soma_sub_aste,
  output logic       enable_mem_aste,
  output logic       enable_load_aste,
  output logic       reset_memoria_load,
  output logic       new_load_aste,
  output logic       new_destruido_aste,
  output logic       reset_gerador_random,
  output logic       reset_reg_nave,
  output logic       enable_reg_nave,
  output logic       pronto,
  output logic       fim_varredura,
  output logic       sem_espaco,
  output logic       colisao,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LIMPA      = 4'd1,
    ESPERA     = 4'd2,
    LE_SPAWN   = 4'd3,
    VER_SPAWN  = 4'd4,
    ESC_SPAWN  = 4'd5,
    LE_MOVE    = 4'd6,
    VER_MOVE   = 4'd7,
    MOVE       = 4'd8,
    ESPERA_MEM = 4'd9,
    CHECA      = 4'd10,
    PROX       = 4'd11,
    FIM        = 4'd12,
    LIBERA     = 4'd13
  } state_t;

  state_t state;
  state_t state_nxt;

  // The current slot sits on the border it is heading towards; one more step
  // would wrap the 4-bit coordinate, so the asteroid is retired instead.
  logic at_edge;

  always_comb begin
    at_edge = 1'b0;
    case (opcode_aste)
      2'b00:   at_edge = (aste_coor_x == 4'd15);
      2'b01:   at_edge = (aste_coor_x == 4'd0);
      2'b10:   at_edge = (aste_coor_y == 4'd15);
      default: at_edge = (aste_coor_y == 4'd0);
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (iniciar) state_nxt = LIMPA;
      LIMPA:      state_nxt = ESPERA;
      ESPERA: begin
        if (spawn)          state_nxt = LE_SPAWN;
        else if (tick_move) state_nxt = LE_MOVE;
      end
      LE_SPAWN:   state_nxt = VER_SPAWN;
      VER_SPAWN: begin
        if (!loaded_aste)            state_nxt = ESC_SPAWN;
        else if (rco_contador_aste)  state_nxt = FIM;
        else                         state_nxt = LE_SPAWN;
      end
      ESC_SPAWN:  state_nxt = FIM;
      LE_MOVE:    state_nxt = VER_MOVE;
      VER_MOVE: begin
        if (loaded_aste && !destruido_aste) state_nxt = at_edge ? LIBERA : MOVE;
        else                                state_nxt = PROX;
      end
      MOVE:       state_nxt = ESPERA_MEM;
      ESPERA_MEM: state_nxt = CHECA;
      CHECA:      state_nxt = PROX;
      PROX:       state_nxt = rco_contador_aste ? FIM : LE_MOVE;
      FIM:        state_nxt = ESPERA;
      LIBERA:     state_nxt = PROX;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output logic. A few outputs also look at the current slot status, so that
  // the counter step and the status writes happen in the same cycle as the decision.
  always_comb begin
    conta_contador_aste  = 1'b0;
    reset_contador_aste  = 1'b0;
    select_mux_pos_aste  = 2'b11;
    select_mux_coor_aste = 1'b0;
    select_soma_sub_aste = 1'b0;
    enable_mem_aste      = 1'b0;
    enable_load_aste     = 1'b0;
    reset_memoria_load   = 1'b0;
    new_load_aste        = 1'b0;
    new_destruido_aste   = 1'b0;
    reset_gerador_random = 1'b0;
    reset_reg_nave       = 1'b0;
    enable_reg_nave      = 1'b0;
    pronto               = 1'b0;
    fim_varredura        = 1'b0;
    sem_espaco           = 1'b0;
    case (state)
      LIMPA: begin
        reset_contador_aste  = 1'b1;
        reset_memoria_load   = 1'b1;
        reset_gerador_random = 1'b1;
        reset_reg_nave       = 1'b1;
      end
      ESPERA: begin
        pronto          = 1'b1;
        enable_reg_nave = 1'b1;
      end
      VER_SPAWN: begin
        // Occupied slot: either the table is full, or look at the next slot.
        if (loaded_aste) begin
          if (rco_contador_aste) sem_espaco          = 1'b1;
          else                   conta_contador_aste = 1'b1;
        end
      end
      ESC_SPAWN: begin
        select_mux_pos_aste = 2'b10;
        enable_mem_aste     = 1'b1;
        enable_load_aste    = 1'b1;
        new_load_aste       = 1'b1;
      end
      MOVE: begin
        // opcode[1] picks the axis, opcode[0] the sign of the step.
        select_mux_coor_aste = opcode_aste[1];
        select_soma_sub_aste = opcode_aste[0];
        select_mux_pos_aste  = {1'b0, opcode_aste[1]};
        enable_mem_aste      = 1'b1;
      end
      CHECA: begin
        // A hit keeps the slot loaded but marks it destroyed, so later scans skip it.
        if (colisao_aste_com_nave) begin
          enable_load_aste   = 1'b1;
          new_load_aste      = 1'b1;
          new_destruido_aste = 1'b1;
        end
      end
      PROX: begin
        if (!rco_contador_aste) conta_contador_aste = 1'b1;
      end
      FIM: begin
        reset_contador_aste = 1'b1;
        fim_varredura       = 1'b1;
      end
      LIBERA: begin
        enable_load_aste = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sticky collision flag: set by any hit during a scan, cleared only when a
  // new session starts or by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      colisao <= 1'b0;
    end else if (state == LIMPA) begin
      colisao <= 1'b0;
    end else if (state == CHECA && colisao_aste_com_nave) begin
      colisao <= 1'b1;
    end
  end

  assign db_estado = state;

endmodule

// File: tb/tb_uc_asteroide.sv
module tb_uc_asteroide;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       spawn;
  logic       tick_move;
  logic       rco_contador_aste;
  logic       loaded_aste;
  logic       destruido_aste;
  logic       colisao_aste_com_nave;
  logic [1:0] opcode_aste;
  logic [3:0] aste_coor_x;
  logic [3:0] aste_coor_y;
  logic       conta_contador_aste;
  logic       reset_contador_aste;
  logic [1:0] select_mux_pos_aste;
  logic       select_mux_coor_aste;
  logic       select_soma_sub_aste;
  logic       enable_mem_aste;
  logic       enable_load_aste;
  logic       reset_memoria_load;
  logic       new_load_aste;
  logic       new_destruido_aste;
  logic       reset_gerador_random;
  logic       reset_reg_nave;
  logic       enable_reg_nave;
  logic       pronto;
  logic       fim_varredura;
  logic       sem_espaco;
  logic       colisao;
  logic [3:0] db_estado;

  uc_asteroide dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .spawn(spawn), .tick_move(tick_move),
    .rco_contador_aste(rco_contador_aste), .loaded_aste(loaded_aste),
    .destruido_aste(destruido_aste), .colisao_aste_com_nave(colisao_aste_com_nave),
    .opcode_aste(opcode_aste), .aste_coor_x(aste_coor_x), .aste_coor_y(aste_coor_y),
    .conta_contador_aste(conta_contador_aste), .reset_contador_aste(reset_contador_aste),
    .select_mux_pos_aste(select_mux_pos_aste), .select_mux_coor_aste(select_mux_coor_aste),
    .select_soma_sub_aste(select_soma_sub_aste), .enable_mem_aste(enable_mem_aste),
    .enable_load_aste(enable_load_aste), .reset_memoria_load(reset_memoria_load),
    .new_load_aste(new_load_aste), .new_destruido_aste(new_destruido_aste),
    .reset_gerador_random(reset_gerador_random), .reset_reg_nave(reset_reg_nave),
    .enable_reg_nave(enable_reg_nave), .pronto(pronto), .fim_varredura(fim_varredura),
    .sem_espaco(sem_espaco), .colisao(colisao), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural datapath: slot table, slot counter, ship position, random source.
  typedef struct packed {
    logic       l;
    logic       d;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] op;
  } slot_t;

  slot_t      mem     [16];
  slot_t      exp_mem [16];
  logic [3:0] cnt;
  logic [3:0] ship_x, ship_y, rnd_x, rnd_y;
  logic [1:0] rnd_op;

  assign rco_contador_aste     = (cnt == 4'd15);
  assign loaded_aste           = mem[cnt].l;
  assign destruido_aste        = mem[cnt].d;
  assign opcode_aste           = mem[cnt].op;
  assign aste_coor_x           = mem[cnt].x;
  assign aste_coor_y           = mem[cnt].y;
  assign colisao_aste_com_nave = mem[cnt].l && (mem[cnt].x == ship_x) && (mem[cnt].y == ship_y);

  logic [17:0] outv;
  assign outv = {conta_contador_aste, reset_contador_aste, select_mux_pos_aste,
                 select_mux_coor_aste, select_soma_sub_aste, enable_mem_aste, enable_load_aste,
                 reset_memoria_load, new_load_aste, new_destruido_aste, reset_gerador_random,
                 reset_reg_nave, enable_reg_nave, pronto, fim_varredura, sem_espaco, colisao};

  int checks = 0;
  int errors = 0;
  int ver_spawn_n, sem_n, fim_n, mem_wr_n, load_wr_n, busy_n, first_state;
  bit op_to;
  bit exp_col;
  int exp_busy, exp_sem, exp_memwr, exp_loadwr;

  task automatic clear_stats();
    ver_spawn_n = 0; sem_n = 0; fim_n = 0; mem_wr_n = 0; load_wr_n = 0; busy_n = 0;
  endtask

  // One clock: sample controls at the falling edge, apply them to the datapath just after the rising edge.
  task automatic cycle();
    logic       a_conta, a_rstc, a_coor, a_soma, a_enmem, a_enload, a_rstmem, a_newl, a_newd;
    logic [1:0] a_pos;
    logic [3:0] a, src, sum;
    a_conta = conta_contador_aste; a_rstc = reset_contador_aste; a_coor = select_mux_coor_aste;
    a_soma = select_soma_sub_aste; a_enmem = enable_mem_aste; a_enload = enable_load_aste;
    a_rstmem = reset_memoria_load; a_newl = new_load_aste; a_newd = new_destruido_aste;
    a_pos = select_mux_pos_aste; a = cnt;
    if (db_estado == 4'd4) ver_spawn_n++;
    if (sem_espaco) sem_n++;
    if (fim_varredura) fim_n++;
    if (enable_mem_aste) mem_wr_n++;
    if (enable_load_aste) load_wr_n++;
    if (db_estado != 4'd2) busy_n++;
    @(posedge clock);
    #1;
    src = a_coor ? mem[a].y : mem[a].x;
    sum = a_soma ? src - 4'd1 : src + 4'd1;
    if (a_enmem) begin
      case (a_pos)
        2'b00: mem[a].x = sum;
        2'b01: mem[a].y = sum;
        2'b10: begin mem[a].x = rnd_x; mem[a].y = rnd_y; mem[a].op = rnd_op; end
        default: ;
      endcase
    end
    if (a_enload) begin mem[a].l = a_newl; mem[a].d = a_newd; end
    if (a_rstmem) for (int i = 0; i < 16; i++) begin mem[i].l = 1'b0; mem[i].d = 1'b0; end
    if (a_rstc) cnt = 4'd0;
    else if (a_conta) cnt = cnt + 4'd1;
    @(negedge clock);
  endtask

  task automatic do_op(input logic s, input logic t);
    clear_stats();
    op_to = 1'b0;
    spawn = s; tick_move = t;
    cycle();
    spawn = 1'b0; tick_move = 1'b0;
    first_state = int'(db_estado);
    for (int k = 0; k < 200; k++) if (db_estado != 4'd2) cycle();
    if (db_estado != 4'd2) op_to = 1'b1;
  endtask

  task automatic start_session();
    reset = 1'b0; cycle(); cycle();
    reset = 1'b1; cycle();
    iniciar = 1'b1; cycle(); iniciar = 1'b0; cycle();
    exp_col = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  // Reference: the first free slot receives the random asteroid, else no space.
  task automatic model_spawn();
    int free_i = -1;
    for (int i = 0; i < 16; i++) if (free_i < 0 && !exp_mem[i].l) free_i = i;
    exp_sem = 0;
    if (free_i >= 0) begin
      exp_mem[free_i] = {1'b1, 1'b0, rnd_x, rnd_y, rnd_op};
      exp_busy = 2 * (free_i + 1) + 2; exp_memwr = 1; exp_loadwr = 1;
    end else begin
      exp_busy = 33; exp_sem = 1; exp_memwr = 0; exp_loadwr = 0;
    end
  endtask

  // Reference: every live asteroid steps once; leaving the board frees it, landing on the ship destroys it.
  task automatic model_tick();
    int nx, ny;
    exp_busy = 1; exp_sem = 0; exp_memwr = 0; exp_loadwr = 0;
    for (int i = 0; i < 16; i++) begin
      if (exp_mem[i].l && !exp_mem[i].d) begin
        nx = int'(exp_mem[i].x); ny = int'(exp_mem[i].y);
        case (exp_mem[i].op)
          2'd0: nx = nx + 1;
          2'd1: nx = nx - 1;
          2'd2: ny = ny + 1;
          default: ny = ny - 1;
        endcase
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          exp_mem[i].l = 1'b0; exp_mem[i].d = 1'b0; exp_busy += 4; exp_loadwr++;
        end else begin
          exp_mem[i].x = 4'(nx); exp_mem[i].y = 4'(ny); exp_memwr++; exp_busy += 6;
          if (exp_mem[i].x == ship_x && exp_mem[i].y == ship_y) begin
            exp_mem[i].d = 1'b1; exp_col = 1'b1; exp_loadwr++;
          end
        end
      end else begin
        exp_busy += 3;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cycle(); cycle();
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", db_estado); end
    checks++; if (outv !== 18'h0C000) begin errors++; $display("FAIL reset_outputs: got %h want 0c000", outv); end
    iniciar = 1'b1; cycle(); iniciar = 1'b0;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_holds: got %0d want 0", db_estado); end
    reset = 1'b1;
    spawn = 1'b1; tick_move = 1'b1; cycle(); spawn = 1'b0; tick_move = 1'b0;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_ignores_req: got %0d want 0", db_estado); end
  endtask

  task automatic test_start();
    iniciar = 1'b1; cycle(); iniciar = 1'b0;
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL limpa_state: got %0d want 1", db_estado); end
    checks++;
    if ({reset_contador_aste, reset_memoria_load, reset_gerador_random, reset_reg_nave, pronto} !== 5'b11110) begin
      errors++; $display("FAIL limpa_resets: got %b want 11110",
        {reset_contador_aste, reset_memoria_load, reset_gerador_random, reset_reg_nave, pronto});
    end
    cycle();
    checks++; if ({db_estado, pronto, enable_reg_nave} !== 6'b0010_11) begin
      errors++; $display("FAIL espera_ready: got state %0d pronto %b nave %b want 2 1 1", db_estado, pronto, enable_reg_nave);
    end
    iniciar = 1'b1; cycle(); iniciar = 1'b0;
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL iniciar_ignored: got %0d want 2", db_estado); end
  endtask

  task automatic test_spawn_first();
    rnd_x = 4'd9; rnd_y = 4'd2; rnd_op = 2'd3;
    spawn = 1'b1; cycle(); spawn = 1'b0;
    checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL spawn_le: got %0d want 3", db_estado); end
    cycle(); cycle();
    checks++;
    if ({db_estado, cnt, select_mux_pos_aste, enable_mem_aste, enable_load_aste, new_load_aste, new_destruido_aste}
        !== {4'd5, 4'd0, 2'b10, 4'b1110}) begin
      errors++; $display("FAIL esc_spawn: got state %0d addr %0d pos %b wr %b%b%b%b want 5 0 10 1110", db_estado, cnt,
        select_mux_pos_aste, enable_mem_aste, enable_load_aste, new_load_aste, new_destruido_aste);
    end
    cycle();
    checks++; if ({db_estado, fim_varredura} !== 5'b1100_1) begin
      errors++; $display("FAIL spawn_fim: got state %0d fim %b want 12 1", db_estado, fim_varredura);
    end
    cycle();
    checks++; if ({db_estado, fim_varredura} !== 5'b0010_0) begin
      errors++; $display("FAIL spawn_done: got state %0d fim %b want 2 0", db_estado, fim_varredura);
    end
    checks++; if (mem[0] !== {1'b1, 1'b0, 4'd9, 4'd2, 2'd3} || mem[1].l !== 1'b0) begin
      errors++; $display("FAIL spawn_slot0: got %h want %h", mem[0], {1'b1, 1'b0, 4'd9, 4'd2, 2'd3});
    end
  endtask

  task automatic test_spawn_full();
    for (int i = 0; i < 16; i++) mem[i].l = 1'b1;
    do_op(1'b1, 1'b0);
    checks++; if (op_to || ver_spawn_n != 16) begin errors++; $display("FAIL full_visits: got %0d want 16 (timeout %b)", ver_spawn_n, op_to); end
    checks++; if (sem_n != 1) begin errors++; $display("FAIL full_sem_espaco: got %0d want 1", sem_n); end
    checks++; if (mem_wr_n + load_wr_n != 0) begin errors++; $display("FAIL full_no_write: got %0d want 0", mem_wr_n + load_wr_n); end
    checks++; if (busy_n != 33) begin errors++; $display("FAIL full_cycles: got %0d want 33", busy_n); end
  endtask

  task automatic test_priority();
    clear_table();
    mem[0] = {1'b1, 1'b0, 4'd3, 4'd3, 2'd0};
    ship_x = 4'd0; ship_y = 4'd15;
    rnd_x = 4'd7; rnd_y = 4'd8; rnd_op = 2'd1;
    for (int i = 0; i < 16; i++) exp_mem[i] = mem[i];
    model_spawn();
    do_op(1'b1, 1'b1);
    checks++; if (first_state != 3) begin errors++; $display("FAIL priority_state: got %0d want 3", first_state); end
    checks++; if (mem[0] !== exp_mem[0] || mem[1] !== exp_mem[1]) begin
      errors++; $display("FAIL priority_table: got %h %h want %h %h", mem[0], mem[1], exp_mem[0], exp_mem[1]);
    end
  endtask

  task automatic test_move_dir();
    logic [3:0] sel_tab [4];
    logic [7:0] pos_tab [4];
    bit found;
    sel_tab[0] = 4'b0000; sel_tab[1] = 4'b0100; sel_tab[2] = 4'b1001; sel_tab[3] = 4'b1101;
    pos_tab[0] = {4'd6, 4'd5}; pos_tab[1] = {4'd4, 4'd5}; pos_tab[2] = {4'd5, 4'd6}; pos_tab[3] = {4'd5, 4'd4};
    ship_x = 4'd0; ship_y = 4'd0;
    for (int j = 0; j < 4; j++) begin
      clear_table();
      mem[3] = {1'b1, 1'b0, 4'd5, 4'd5, 2'(j)};
      found = 1'b0;
      tick_move = 1'b1; cycle(); tick_move = 1'b0;
      for (int k = 0; k < 60; k++) if (!found) begin
        if (db_estado == 4'd8) found = 1'b1; else cycle();
      end
      checks++;
      if (!found || cnt !== 4'd3 || enable_mem_aste !== 1'b1 ||
          {select_mux_coor_aste, select_soma_sub_aste, select_mux_pos_aste} !== sel_tab[j]) begin
        errors++; $display("FAIL move_sel op %0d: got found %b addr %0d sel %b mem %b want 1 3 %b 1", j, found, cnt,
          {select_mux_coor_aste, select_soma_sub_aste, select_mux_pos_aste}, enable_mem_aste, sel_tab[j]);
      end
      for (int k = 0; k < 100; k++) if (db_estado != 4'd2) cycle();
      checks++; if ({mem[3].x, mem[3].y} !== pos_tab[j] || db_estado !== 4'd2) begin
        errors++; $display("FAIL move_pos op %0d: got %h want %h", j, {mem[3].x, mem[3].y}, pos_tab[j]);
      end
    end
  endtask

  task automatic test_edge();
    logic [7:0] edge_tab [4];
    bit found;
    edge_tab[0] = {4'd15, 4'd3}; edge_tab[1] = {4'd0, 4'd3}; edge_tab[2] = {4'd3, 4'd15}; edge_tab[3] = {4'd3, 4'd0};
    for (int j = 0; j < 4; j++) begin
      clear_table();
      mem[6] = {1'b1, 1'b0, edge_tab[j], 2'(j)};
      found = 1'b0;
      clear_stats();
      tick_move = 1'b1; cycle(); tick_move = 1'b0;
      for (int k = 0; k < 60; k++) if (!found) begin
        if (db_estado == 4'd13) found = 1'b1; else cycle();
      end
      checks++;
      if (!found || {enable_load_aste, new_load_aste, new_destruido_aste, enable_mem_aste} !== 4'b1000) begin
        errors++; $display("FAIL libera op %0d: got found %b ld/nl/nd/mem %b want 1 1000", j, found,
          {enable_load_aste, new_load_aste, new_destruido_aste, enable_mem_aste});
      end
      for (int k = 0; k < 100; k++) if (db_estado != 4'd2) cycle();
      checks++; if (mem_wr_n != 0 || mem[6].l !== 1'b0 || {mem[6].x, mem[6].y} !== edge_tab[j]) begin
        errors++; $display("FAIL libera_result op %0d: got memwr %0d loaded %b pos %h want 0 0 %h", j, mem_wr_n,
          mem[6].l, {mem[6].x, mem[6].y}, edge_tab[j]);
      end
    end
  endtask

  task automatic test_collision_reset();
    bit found;
    clear_table();
    mem[2] = {1'b1, 1'b0, 4'd4, 4'd4, 2'd2};
    ship_x = 4'd4; ship_y = 4'd5;
    found = 1'b0;
    tick_move = 1'b1; cycle(); tick_move = 1'b0;
    for (int k = 0; k < 60; k++) if (!found) begin
      if (db_estado == 4'd10) found = 1'b1; else cycle();
    end
    checks++;
    if (!found || {enable_load_aste, new_load_aste, new_destruido_aste, colisao} !== 4'b1110) begin
      errors++; $display("FAIL checa_hit: got found %b ld/nl/nd/col %b want 1 1110", found,
        {enable_load_aste, new_load_aste, new_destruido_aste, colisao});
    end
    cycle();
    checks++; if ({db_estado, colisao} !== 5'b1011_1) begin
      errors++; $display("FAIL colisao_set: got state %0d col %b want 11 1", db_estado, colisao);
    end
    for (int k = 0; k < 100; k++) if (db_estado != 4'd2) cycle();
    checks++; if (colisao !== 1'b1 || mem[2].d !== 1'b1 || mem[2].l !== 1'b1) begin
      errors++; $display("FAIL colisao_sticky: got col %b l %b d %b want 1 1 1", colisao, mem[2].l, mem[2].d);
    end
    tick_move = 1'b1; cycle(); tick_move = 1'b0;
    for (int k = 0; k < 7; k++) cycle();
    reset = 1'b0;
    #1;
    checks++; if ({db_estado, colisao, outv} !== {4'd0, 1'b0, 18'h0C000}) begin
      errors++; $display("FAIL midscan_reset: got state %0d col %b out %h want 0 0 0c000", db_estado, colisao, outv);
    end
    @(negedge clock);
    reset = 1'b1; cycle();
  endtask

  task automatic preload();
    int r;
    ship_x = 4'($urandom_range(1, 14)); ship_y = 4'($urandom_range(1, 14));
    for (int i = 0; i < 16; i++) begin
      mem[i].l  = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      mem[i].d  = (mem[i].l && $urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      mem[i].op = 2'($urandom_range(0, 3));
      mem[i].x  = 4'($urandom_range(0, 15));
      mem[i].y  = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        case (mem[i].op)
          2'd0: mem[i].x = 4'd15;
          2'd1: mem[i].x = 4'd0;
          2'd2: mem[i].y = 4'd15;
          default: mem[i].y = 4'd0;
        endcase
      end else if (r == 1) begin
        case (mem[i].op)
          2'd0: begin mem[i].x = ship_x - 4'd1; mem[i].y = ship_y; end
          2'd1: begin mem[i].x = ship_x + 4'd1; mem[i].y = ship_y; end
          2'd2: begin mem[i].x = ship_x; mem[i].y = ship_y - 4'd1; end
          default: begin mem[i].x = ship_x; mem[i].y = ship_y + 4'd1; end
        endcase
      end
    end
  endtask

  task automatic test_random();
    int  kind;
    bit  bad;
    start_session();
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) preload();
      rnd_x = 4'($urandom_range(0, 15)); rnd_y = 4'($urandom_range(0, 15)); rnd_op = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) exp_mem[i] = mem[i];
      if (kind == 2) model_tick(); else model_spawn();
      do_op((kind != 2) ? 1'b1 : 1'b0, (kind >= 2) ? 1'b1 : 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) begin
        if (!bad) $display("FAIL rand_table op %0d kind %0d slot %0d: got %h want %h", n, kind, i, mem[i], exp_mem[i]);
        bad = 1'b1;
      end
      checks++; if (bad) errors++;
      checks++; if (op_to || busy_n != exp_busy) begin
        errors++; $display("FAIL rand_cycles op %0d: got %0d want %0d (timeout %b)", n, busy_n, exp_busy, op_to);
      end
      checks++; if (fim_n != 1 || sem_n != exp_sem) begin
        errors++; $display("FAIL rand_pulses op %0d: got fim %0d sem %0d want 1 %0d", n, fim_n, sem_n, exp_sem);
      end
      checks++; if (mem_wr_n != exp_memwr || load_wr_n != exp_loadwr) begin
        errors++; $display("FAIL rand_writes op %0d: got mem %0d load %0d want %0d %0d", n, mem_wr_n, load_wr_n, exp_memwr, exp_loadwr);
      end
      checks++; if (colisao !== exp_col) begin
        errors++; $display("FAIL rand_colisao op %0d: got %b want %b", n, colisao, exp_col);
      end
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; spawn = 1'b0; tick_move = 1'b0;
    cnt = 4'd0; ship_x = 4'd0; ship_y = 4'd0; rnd_x = 4'd0; rnd_y = 4'd0; rnd_op = 2'd0;
    exp_col = 1'b0; op_to = 1'b0; first_state = 0;
    exp_busy = 0; exp_sem = 0; exp_memwr = 0; exp_loadwr = 0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    clear_stats();
    @(negedge clock);
    test_reset();
    test_start();
    test_spawn_first();
    test_spawn_full();
    test_priority();
    test_move_dir();
    test_edge();
    test_collision_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
